// File: rtl/hex_rate_counter.sv
// Two-digit hex counter stepped by a selectable-rate divider; the 8-bit count
// is split into two nibbles for the board's seven-segment decoders.
module hex_rate_counter #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [1:0] speed,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       tick,
  output logic       wrap
);

  localparam int DIV_W = $clog2(4 * CLK_HZ);

  localparam logic [DIV_W-1:0] RELOAD_FAST = '0;
  localparam logic [DIV_W-1:0] RELOAD_1HZ  = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] RELOAD_HALF = DIV_W'(2 * CLK_HZ - 1);
  localparam logic [DIV_W-1:0] RELOAD_QTR  = DIV_W'(4 * CLK_HZ - 1);

  logic [7:0]       r_count;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_speed_q;
  logic             r_tick;
  logic             r_wrap;

  logic [DIV_W-1:0] w_reload;
  logic [7:0]       w_count_next;
  logic             w_wrap_next;
  logic             w_speed_change;
  logic             w_div_zero;

  // Reload value always follows the live speed input, so a load or a
  // speed-change edge picks up the new period immediately.
  always_comb begin
    w_reload = RELOAD_FAST;
    case (speed)
      2'b00:   w_reload = RELOAD_FAST;
      2'b01:   w_reload = RELOAD_1HZ;
      2'b10:   w_reload = RELOAD_HALF;
      2'b11:   w_reload = RELOAD_QTR;
      default: w_reload = RELOAD_FAST;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (up) begin
      w_count_next = r_count + 8'd1;
      w_wrap_next  = (r_count == 8'hFF);
    end else begin
      w_count_next = r_count - 8'd1;
      w_wrap_next  = (r_count == 8'h00);
    end
  end

  assign w_speed_change = (speed != r_speed_q);
  assign w_div_zero     = (r_div == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= 8'h00;
      r_div     <= '0;
      r_speed_q <= 2'b00;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_speed_q <= speed;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      if (load) begin
        r_count <= load_val;
        r_div   <= w_reload;
      end else if (w_speed_change) begin
        r_div <= w_reload;
      end else if (en) begin
        if (!w_div_zero) begin
          r_div <= r_div - 1'b1;
        end else begin
          r_div   <= w_reload;
          r_count <= w_count_next;
          r_tick  <= 1'b1;
          r_wrap  <= w_wrap_next;
        end
      end
    end
  end

  assign digit0 = r_count[3:0];
  assign digit1 = r_count[7:4];
  assign tick   = r_tick;
  assign wrap   = r_wrap;

endmodule
